// File: rtl/clk_en_pkg.sv
// Shared types and sizing helpers for the NCO clock-enable bank.
package clk_en_pkg;

  localparam int ACC_W_DEF = 32;

  typedef logic [ACC_W_DEF-1:0] acc_t;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int lock_cnt_w(input int lock_cycles);
    return (lock_cycles > 1) ? $clog2(lock_cycles) : 1;
  endfunction

endpackage

// File: rtl/clk_en_nco.sv
// One NCO channel: phase accumulator, shadowed increment with carry-aligned retune.
// CLKEN_TOGGLE_OUT_EN adds a divide-by-two toggle output for test points.
module clk_en_nco #(
  parameter int               ACC_W   = 32,
  parameter logic [ACC_W-1:0] INC_RST = '0
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic [ACC_W-1:0] wr_inc_i,
  output logic             ce_o,
  output logic             pend_o,
  output logic             apply_o
`ifdef CLKEN_TOGGLE_OUT_EN
  ,
  output logic             tgl_o
`endif
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             apply;

  assign sum   = {1'b0, acc_q} + {1'b0, inc_q};
  assign carry = sum[ACC_W];
  // Retune only at a wrap (or when stopped) so no enable period is ever truncated.
  assign apply = pend_q && (carry || (inc_q == '0));

  always_comb begin
    acc_d    = sum[ACC_W-1:0];
    ce_d     = carry;
    inc_d    = apply ? shadow_q : inc_q;
    shadow_d = wr_i ? wr_inc_i : shadow_q;
    pend_d   = wr_i | (pend_q & ~apply);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      acc_q    <= '0;
      inc_q    <= INC_RST;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      ce_q     <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      inc_q    <= inc_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      ce_q     <= ce_d;
    end
  end

  assign ce_o    = ce_q;
  assign pend_o  = pend_q;
  assign apply_o = apply;

`ifdef CLKEN_TOGGLE_OUT_EN
  logic tgl_q;

  always_ff @(posedge refclk) begin
    if (rst) tgl_q <= 1'b0;
    else     tgl_q <= tgl_q ^ ce_q;
  end

  assign tgl_o = tgl_q;
`endif

endmodule

// File: rtl/clk_en_nco_bank.sv
// Multi-channel fractional clock-enable generator: write decode, lock tracking, packing.
// CLKEN_TOGGLE_OUT_EN adds the clk_tgl square-wave test outputs.
module clk_en_nco_bank
  import clk_en_pkg::*;
#(
  parameter int                      NUM_CH      = 3,
  parameter int                      ACC_W       = 32,
  parameter int                      LOCK_CYCLES = 256,
  parameter logic [NUM_CH*ACC_W-1:0] INC_DEFAULT = {32'd2459813670, 32'd2147483648, 32'd1229906835}
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ch_w(NUM_CH)-1:0] wr_ch,
  input  logic [ACC_W-1:0]        wr_inc,
  output logic [NUM_CH-1:0]       ce_out,
  output logic [NUM_CH-1:0]       pend,
  output logic                    locked
`ifdef CLKEN_TOGGLE_OUT_EN
  ,
  output logic [NUM_CH-1:0]       clk_tgl
`endif
);

  localparam int            CH_W     = ch_w(NUM_CH);
  localparam int            LCW      = lock_cnt_w(LOCK_CYCLES);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CYCLES - 1);

  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] apply;
  logic [LCW-1:0]    cnt_q, cnt_d;
  logic              locked_q, locked_d;
  logic              any_apply;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range channel numbers match no instance, so they are dropped here.
    assign wr_hit[i] = wr_en && (wr_ch == CH_W'(i));

    clk_en_nco #(
      .ACC_W   (ACC_W),
      .INC_RST (INC_DEFAULT[i*ACC_W +: ACC_W])
    ) u_nco (
      .refclk   (refclk),
      .rst      (rst),
      .wr_i     (wr_hit[i]),
      .wr_inc_i (wr_inc),
      .ce_o     (ce_out[i]),
      .pend_o   (pend[i]),
      .apply_o  (apply[i])
`ifdef CLKEN_TOGGLE_OUT_EN
      ,
      .tgl_o    (clk_tgl[i])
`endif
    );
  end

  assign any_apply = |apply;

  always_comb begin
    cnt_d    = cnt_q;
    locked_d = 1'b0;
    if (any_apply) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != LOCK_MAX) cnt_d = cnt_q + 1'b1;
      locked_d = (cnt_q == LOCK_MAX);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q & ~(|pend);

endmodule

// File: tb/tb_clk_en_nco_bank.sv
// Directed and randomized bench for clk_en_nco_bank against an arithmetic rate model.
module tb_clk_en_nco_bank;

  localparam int NUM_CH = 3;
  localparam int LOCK   = 256;
  localparam longint unsigned TWO32 = 64'h1_0000_0000;

  logic        refclk = 1'b0;
  logic        rst    = 1'b1;
  logic        wr_en  = 1'b0;
  logic [1:0]  wr_ch  = '0;
  logic [31:0] wr_inc = '0;
  logic [2:0]  ce_out;
  logic [2:0]  pend;
  logic        locked;
`ifdef CLKEN_TOGGLE_OUT_EN
  logic [2:0]  clk_tgl;
`endif

  clk_en_nco_bank dut (
    .refclk (refclk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_inc (wr_inc),
    .ce_out (ce_out),
    .pend   (pend),
    .locked (locked)
`ifdef CLKEN_TOGGLE_OUT_EN
    ,
    .clk_tgl (clk_tgl)
`endif
  );

  always #10 refclk = ~refclk;

  int checks = 0;
  int errors = 0;

  longint unsigned def_inc [NUM_CH] = '{64'd1229906835, 64'd2147483648, 64'd2459813670};
  longint unsigned m_acc [NUM_CH];
  longint unsigned m_inc [NUM_CH];
  longint unsigned m_sh  [NUM_CH];
  bit              m_pend[NUM_CH];
  bit              m_ce  [NUM_CH];
  bit              m_tgl [NUM_CH];
  int              m_since;
  int              pcnt  [NUM_CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rate model: each edge adds inc to the phase; a wrap past 2^32 is a pulse.
  task automatic model_edge(input bit r, input bit we, input int ch, input longint unsigned v);
    bit any_ap;
    longint unsigned s;
    any_ap = 0;
    if (r) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_acc[i] = 0; m_inc[i] = def_inc[i]; m_sh[i] = 0;
        m_pend[i] = 0; m_ce[i] = 0; m_tgl[i] = 0;
      end
      m_since = 0;
      return;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      m_tgl[i] = m_tgl[i] ^ m_ce[i];
      s = m_acc[i] + m_inc[i];
      m_ce[i] = (s >= TWO32);
      m_acc[i] = s % TWO32;
      if (m_pend[i] && (m_ce[i] || m_inc[i] == 0)) begin
        m_inc[i] = m_sh[i];
        m_pend[i] = 0;
        any_ap = 1;
      end
    end
    if (we && ch < NUM_CH) begin
      m_sh[ch] = v;
      m_pend[ch] = 1;
    end
    if (any_ap) m_since = 0;
    else if (m_since < LOCK) m_since++;
  endtask

  task automatic cyc(input bit r, input bit we, input int ch, input longint unsigned v);
    logic [2:0] e_ce, e_pend, e_tgl;
    bit any_p;
    rst = r; wr_en = we; wr_ch = 2'(ch); wr_inc = 32'(v);
    @(posedge refclk);
    model_edge(r, we, ch, v);
    #1;
    any_p = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      e_ce[i] = m_ce[i]; e_pend[i] = m_pend[i]; e_tgl[i] = m_tgl[i];
      any_p |= m_pend[i];
      pcnt[i] += int'(ce_out[i]);
    end
    chk("ce_out", 64'(ce_out), 64'(e_ce));
    chk("pend", 64'(pend), 64'(e_pend));
    chk("locked", 64'(locked), 64'((m_since >= LOCK) && !any_p));
`ifdef CLKEN_TOGGLE_OUT_EN
    chk("clk_tgl", 64'(clk_tgl), 64'(e_tgl));
`endif
    rst = 1'b0; wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0);
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < NUM_CH; i++) pcnt[i] = 0;
  endtask

  initial begin
    int lk_at, gmin, gmax, last0, n, e0, e2;
    longint unsigned rv;

    // Reset
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0);
    chk("rst_ce", 64'(ce_out), 0);
    chk("rst_pend", 64'(pend), 0);
    chk("rst_locked", 64'(locked), 0);

    // Free-running default rates, lock timing, ch1 alternation
    clr_cnt();
    lk_at = -1; last0 = -1; gmin = 1000; gmax = 0;
    for (int k = 1; k <= 4096; k++) begin
      cyc(0, 0, 0, 0);
      if (k <= 1000) chk("ch1_alt", 64'(ce_out[1]), 64'(k % 2 == 0));
      if (k == 1000) chk("ch1_500", 64'(pcnt[1]), 500);
      if (locked && lk_at < 0) lk_at = k;
      if (ce_out[0]) begin
        if (last0 >= 0) begin
          if (k - last0 < gmin) gmin = k - last0;
          if (k - last0 > gmax) gmax = k - last0;
        end
        last0 = k;
      end
    end
    chk("lock_rise", 64'(lk_at), LOCK);
    e0 = int'((64'd4096 * def_inc[0]) >> 32);
    e2 = int'((64'd4096 * def_inc[2]) >> 32);
    chk("ch0_rate", 64'(pcnt[0] == e0 || pcnt[0] == e0 - 1), 1);
    chk("ch2_rate", 64'(pcnt[2] == e2 || pcnt[2] == e2 - 1), 1);
    chk("ch0_gap_min", 64'(gmin), 3);
    chk("ch0_gap_max", 64'(gmax), 4);

    // Retune ch1 to 2^30: pend, apply on carry, period 4, relock
    cyc(0, 1, 1, 64'h4000_0000);
    chk("ch1_pend_set", 64'(pend[1]), 1);
    n = 0;
    while (pend[1] && n < 8) begin cyc(0, 0, 0, 0); n++; end
    chk("ch1_applied", 64'(pend[1]), 0);
    clr_cnt();
    n = 0;
    while (!locked && n < 400) begin cyc(0, 0, 0, 0); n++; end
    chk("relock_delay", 64'(n), LOCK);
    chk("ch1_period4", 64'(pcnt[1]), LOCK / 4);

    // Stop ch2, then restart at half rate via the inc==0 rule
    cyc(0, 1, 2, 0);
    n = 0;
    while (pend[2] && n < 8) begin cyc(0, 0, 0, 0); n++; end
    chk("ch2_stop_applied", 64'(pend[2]), 0);
    idle(1);
    clr_cnt();
    idle(20);
    chk("ch2_stopped", 64'(pcnt[2]), 0);
    cyc(0, 1, 2, 64'h8000_0000);
    chk("ch2_pend", 64'(pend[2]), 1);
    cyc(0, 0, 0, 0);
    chk("ch2_zero_apply", 64'(pend[2]), 0);
    clr_cnt();
    idle(20);
    chk("ch2_resume", 64'(pcnt[2]), 10);

    // Out-of-range channel, then back-to-back writes
    n = 0;
    while (!locked && n < 400) begin cyc(0, 0, 0, 0); n++; end
    chk("locked_before_bad", 64'(locked), 1);
    cyc(0, 1, 3, 64'd12345);
    chk("bad_ch_pend", 64'(pend), 0);
    chk("bad_ch_locked", 64'(locked), 1);
    cyc(0, 1, 1, 5);
    cyc(0, 1, 1, 7);
    idle(8);

    // Reset mid-run with a pending write
    cyc(0, 1, 0, 64'h0010_0000);
    chk("ch0_pend", 64'(pend[0]), 1);
    cyc(1, 0, 0, 0);
    chk("mid_rst_ce", 64'(ce_out), 0);
    chk("mid_rst_pend", 64'(pend), 0);
    chk("mid_rst_locked", 64'(locked), 0);
    clr_cnt();
    idle(1000);
    chk("ch1_revert", 64'(pcnt[1]), 500);

    // Randomized writes and occasional resets against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(399) == 0) cyc(1, 0, 0, 0);
      else if ($urandom_range(19) == 0) begin
        case ($urandom_range(3))
          0: rv = 0;
          1: rv = 64'h8000_0000;
          2: rv = 64'h4000_0000;
          default: rv = 64'({4'b0001, 28'($urandom)}) << $urandom_range(3);
        endcase
        cyc(0, 1, int'($urandom_range(3)), rv);
      end else cyc(0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
